// File: rtl/button_event_gen_pkg.sv
// button_event_gen_pkg
//   Shared definitions for push-button event generation and other consumers
//   of the 5 ms timer strobe.
//   Contents:
//     state_t     - 2-bit FSM encoding: ARM, IDLE, PRESSED, REPEATING
//     TICKS_1S    - 200 ticks of the 5 ms strobe (1 s)
//     TICKS_200MS - 40 ticks of the 5 ms strobe (200 ms)
package button_event_gen_pkg;

  typedef enum logic [1:0] {
    ARM       = 2'd0,
    IDLE      = 2'd1,
    PRESSED   = 2'd2,
    REPEATING = 2'd3
  } state_t;

  localparam int TICKS_1S    = 200;
  localparam int TICKS_200MS = 40;

endpackage

// File: rtl/button_event_gen.sv
// button_event_gen
//   Turns the clean DEBOUNCED button level into one-CLK user events:
//   SHORT_PRESS on release before the long-press time, LONG_PRESS once the
//   hold reaches LONG_TICKS strobes of PULSE_5MS, and (optionally) REPEAT
//   every REPEAT_TICKS strobes while the button stays held afterwards.
//   Hold time is counted in PULSE_5MS ticks. All outputs are registered.
//
//   Optional feature macro: BTN_AUTO_REPEAT_EN
//     defined   - REPEATING emits REPEAT strobes every REPEAT_TICKS ticks
//     undefined - REPEAT is tied to 0, REPEATING just waits for release
//
//   Ports:
//     CLK          in   system clock
//     RESET        in   synchronous, active-high reset
//     PULSE_5MS    in   one-CLK strobe every 5 ms
//     DEBOUNCED    in   clean button level, 1 = pressed
//     SHORT_PRESS  out  one-CLK strobe, released before LONG_TICKS elapsed
//     LONG_PRESS   out  one-CLK strobe, hold reached LONG_TICKS
//     REPEAT       out  one-CLK strobe every REPEAT_TICKS after LONG_PRESS
//     HELD         out  level, button accepted as pressed
module button_event_gen
  import button_event_gen_pkg::*;
#(
  parameter int LONG_TICKS   = TICKS_1S,
  parameter int REPEAT_TICKS = TICKS_200MS,
  parameter int CNT_W        = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic PULSE_5MS,
  input  logic DEBOUNCED,
  output logic SHORT_PRESS,
  output logic LONG_PRESS,
  output logic REPEAT,
  output logic HELD
);

  // Reject tick counts the hold counter cannot represent.
  if (LONG_TICKS < 2 || LONG_TICKS > (2**CNT_W) - 1) begin : g_bad_long
    $error("button_event_gen: LONG_TICKS out of range for CNT_W");
  end
  if (REPEAT_TICKS < 1 || REPEAT_TICKS > (2**CNT_W) - 1) begin : g_bad_repeat
    $error("button_event_gen: REPEAT_TICKS out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             short_nxt, long_nxt, repeat_nxt, held_nxt;
  logic             repeat_q;

  // State, counter and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ARM;
      cnt         <= '0;
      SHORT_PRESS <= 1'b0;
      LONG_PRESS  <= 1'b0;
      repeat_q    <= 1'b0;
      HELD        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      SHORT_PRESS <= short_nxt;
      LONG_PRESS  <= long_nxt;
      repeat_q    <= repeat_nxt;
      HELD        <= held_nxt;
    end
  end

  // Next-state and hold counter. Release is tested first in every held
  // state so it always beats a threshold tick in the same cycle. A tick in
  // the IDLE->PRESSED cycle is deliberately not counted.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ARM: begin
        if (!DEBOUNCED) state_nxt = IDLE;
      end
      IDLE: begin
        if (DEBOUNCED) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end
      end
      PRESSED: begin
        if (!DEBOUNCED) begin
          state_nxt = IDLE;
        end else if (PULSE_5MS && cnt == LONG_LAST) begin
          state_nxt = REPEATING;
          cnt_nxt   = '0;
        end else if (PULSE_5MS) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      REPEATING: begin
        if (!DEBOUNCED) begin
          state_nxt = IDLE;
`ifdef BTN_AUTO_REPEAT_EN
        end else if (PULSE_5MS && cnt == REPEAT_LAST) begin
          cnt_nxt = '0;
        end else if (PULSE_5MS) begin
          cnt_nxt = cnt + 1'b1;
`endif
        end
      end
      default: begin
        state_nxt = ARM;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode, registered above so every strobe lands one CLK later.
  always_comb begin
    short_nxt  = (state == PRESSED) && !DEBOUNCED;
    long_nxt   = (state == PRESSED) && DEBOUNCED && PULSE_5MS &&
                 (cnt == LONG_LAST);
`ifdef BTN_AUTO_REPEAT_EN
    repeat_nxt = (state == REPEATING) && DEBOUNCED && PULSE_5MS &&
                 (cnt == REPEAT_LAST);
`else
    repeat_nxt = 1'b0;
`endif
    held_nxt   = (state_nxt == PRESSED) || (state_nxt == REPEATING);
  end

`ifdef BTN_AUTO_REPEAT_EN
  assign REPEAT = repeat_q;
`else
  assign REPEAT = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen
//   Self-checking bench for button_event_gen with LONG_TICKS = 4,
//   REPEAT_TICKS = 2 and a PULSE_5MS strobe every 10 CLK. A behavioural
//   model tracks the hold time as a running tick count since the press and
//   derives the expected strobes from it; outputs are compared 1 time unit
//   after every rising edge. Directed scenarios are followed by random
//   press/hold/release/reset sequences.
module tb_button_event_gen;
  import button_event_gen_pkg::*;

  localparam int LONG_T   = 4;
  localparam int REPEAT_T = 2;
  localparam int PERIOD   = 10;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic PULSE_5MS = 1'b0;
  logic DEBOUNCED = 1'b0;
  logic SHORT_PRESS, LONG_PRESS, REPEAT, HELD;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state
  bit m_blocked = 1'b1;
  bit m_down    = 1'b0;
  int m_ticks   = 0;
  bit e_short, e_long, e_repeat, e_held;

  button_event_gen #(
    .LONG_TICKS  (LONG_T),
    .REPEAT_TICKS(REPEAT_T),
    .CNT_W       (8)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .PULSE_5MS  (PULSE_5MS),
    .DEBOUNCED  (DEBOUNCED),
    .SHORT_PRESS(SHORT_PRESS),
    .LONG_PRESS (LONG_PRESS),
    .REPEAT     (REPEAT),
    .HELD       (HELD)
  );

  always #5 CLK = ~CLK;

  // Model: after reset the button must be seen released before a press is
  // accepted; a press starts a tick count; the strobes follow from that
  // count (LONG at tick LONG_T, REPEAT every REPEAT_T ticks beyond it), and
  // release is judged before any tick in the same cycle.
  task automatic modelEdge(input bit rst, input bit deb, input bit pul);
    e_short  = 1'b0;
    e_long   = 1'b0;
    e_repeat = 1'b0;
    if (rst) begin
      m_blocked = 1'b1;
      m_down    = 1'b0;
      m_ticks   = 0;
    end else if (m_blocked) begin
      if (!deb) m_blocked = 1'b0;
    end else if (!m_down) begin
      if (deb) begin
        m_down  = 1'b1;
        m_ticks = 0;
      end
    end else if (!deb) begin
      e_short = (m_ticks < LONG_T);
      m_down  = 1'b0;
    end else if (pul) begin
      m_ticks++;
      if (m_ticks == LONG_T)
        e_long = 1'b1;
      else if (REP_EN && m_ticks > LONG_T && ((m_ticks - LONG_T) % REPEAT_T) == 0)
        e_repeat = 1'b1;
    end
    e_held = m_down;
  endtask

  task automatic checkOutput();
    n_checks++;
    assert (SHORT_PRESS === e_short) n_pass++;
    else $error("[TB] FAIL short_press cyc=%0d observed=%b expected=%b", cyc, SHORT_PRESS, e_short);
    n_checks++;
    assert (LONG_PRESS === e_long) n_pass++;
    else $error("[TB] FAIL long_press cyc=%0d observed=%b expected=%b", cyc, LONG_PRESS, e_long);
    n_checks++;
    assert (REPEAT === e_repeat) n_pass++;
    else $error("[TB] FAIL repeat cyc=%0d observed=%b expected=%b", cyc, REPEAT, e_repeat);
    n_checks++;
    assert (HELD === e_held) n_pass++;
    else $error("[TB] FAIL held cyc=%0d observed=%b expected=%b", cyc, HELD, e_held);
  endtask

  // One clock: drive on the falling edge, update the model at the rising
  // edge, compare shortly afterwards.
  task automatic applyStimulus(input bit rst, input bit deb);
    bit pul;
    @(negedge CLK);
    pul       = ((cyc % PERIOD) == PERIOD - 1);
    RESET     = rst;
    DEBOUNCED = deb;
    PULSE_5MS = pul;
    @(posedge CLK);
    modelEdge(rst, deb, pul);
    cyc++;
    #1;
    checkOutput();
  endtask

  task automatic repeatStimulus(input bit rst, input bit deb, input int n);
    for (int i = 0; i < n; i++) applyStimulus(rst, deb);
  endtask

  // Press and keep holding until the model has counted n ticks.
  task automatic holdUntilTick(input int n);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 400 && m_ticks < n; i++) applyStimulus(1'b0, 1'b1);
    n_checks++;
    assert (m_ticks >= n) n_pass++;
    else $error("[TB] FAIL hold_timeout observed=%0d expected=%0d", m_ticks, n);
  endtask

  initial begin
    $display("[TB] start, auto-repeat build = %0b", REP_EN);

    // Held through reset: no events until released and pressed again.
    repeatStimulus(1'b1, 1'b1, 3);
    repeatStimulus(1'b0, 1'b1, 100);
    repeatStimulus(1'b0, 1'b0, 5);
    repeatStimulus(1'b0, 1'b1, 3);
    repeatStimulus(1'b0, 1'b0, 5);

    // Short press of two ticks.
    holdUntilTick(2);
    repeatStimulus(1'b0, 1'b0, 5);

    // Long hold of nine ticks, then release.
    holdUntilTick(9);
    repeatStimulus(1'b0, 1'b0, 20);

    // Release coincides with the threshold tick: release wins.
    holdUntilTick(LONG_T - 1);
    for (int i = 0; i < PERIOD && (cyc % PERIOD) != PERIOD - 1; i++)
      applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    repeatStimulus(1'b0, 1'b0, 5);

    // Reset while repeating; the still-held button produces nothing.
    holdUntilTick(LONG_T + 1);
    applyStimulus(1'b1, 1'b1);
    repeatStimulus(1'b0, 1'b1, 60);
    repeatStimulus(1'b0, 1'b0, 5);

    // Random press/hold/release traffic with occasional resets.
    for (int k = 0; k < 40; k++) begin
      int hold_len;
      int rel_len;
      hold_len = $urandom_range(1, 120);
      rel_len  = $urandom_range(1, 25);
      for (int i = 0; i < hold_len; i++)
        applyStimulus(($urandom_range(0, 199) == 0), 1'b1);
      for (int i = 0; i < rel_len; i++)
        applyStimulus(($urandom_range(0, 99) == 0), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
